// File: rtl/ddc_pkg.sv
// Shared widths and arithmetic helpers for the DDC mixer/CIC decimator.
// Helpers take explicit widths so overridden parameters stay consistent.
package ddc_pkg;

   localparam int DDC_DW    = 12;
   localparam int DDC_MPR   = 12;
   localparam int DDC_OW    = 16;
   localparam int DDC_NSTG  = 3;
   localparam int DDC_LOG2R = 3;

   function automatic int acc_width(input int dw, input int mpr, input int nstg, input int log2r);
      return dw + mpr + nstg * log2r;
   endfunction

   function automatic longint rnd_const(input int acc_w, input int ow);
      return longint'(1) <<< (acc_w - ow - 1);
   endfunction

   // Round-half-up to the top ow bits; only positive overflow of the rounding add is possible.
   function automatic longint sat_trunc(input longint x, input int acc_w, input int ow);
      longint sum;
      longint max_pos;
      sum     = x + rnd_const(acc_w, ow);
      max_pos = (longint'(1) <<< (acc_w - 1)) - 1;
      if (sum > max_pos) return (longint'(1) <<< (ow - 1)) - 1;
      return sum >>> (acc_w - ow);
   endfunction

endpackage

// File: rtl/cic_dec_chan.sv
// One CIC decimation channel: integrators, decimation register, combs, round/clamp.
// tok_i marks a new mixer product; tok_o marks a new rounded output word.
module cic_dec_chan
   import ddc_pkg::*;
#(
   parameter int ACC_W = 33,
   parameter int NSTG  = 3,
   parameter int OW    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clken,
   input  logic             tok_i,
   input  logic [ACC_W-1:0] x_i,
   input  logic             dec_take_i,
   output logic             int_tok_o,
   output logic             tok_o,
   output logic [OW-1:0]    y_o
);

   logic [ACC_W-1:0] int_q [NSTG];
   logic [NSTG-1:0]  int_tok_q;
   logic [ACC_W-1:0] dec_q;
   logic             dec_tok_q;
   logic [ACC_W-1:0] comb_q [NSTG];
   logic [ACC_W-1:0] prev_q [NSTG];
   logic [NSTG-1:0]  comb_tok_q;
   logic [ACC_W-1:0] comb_in [NSTG];
   logic [NSTG-1:0]  comb_in_tok;
   logic [OW-1:0]    y_q, y_d;
   logic             tok_q;

   // NOTE: state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NSTG; k++) int_q[k] <= '0;
         int_tok_q <= '0;
         dec_q     <= '0;
         dec_tok_q <= 1'b0;
      end else if (clken) begin
         int_tok_q <= {int_tok_q[NSTG-2:0], tok_i};
         if (tok_i) int_q[0] <= int_q[0] + x_i;
         for (int k = 1; k < NSTG; k++)
            if (int_tok_q[k-1]) int_q[k] <= int_q[k] + int_q[k-1];
         dec_tok_q <= int_tok_q[NSTG-1] & dec_take_i;
         if (int_tok_q[NSTG-1] && dec_take_i) dec_q <= int_q[NSTG-1];
      end
   end

   assign int_tok_o = int_tok_q[NSTG-1];

   // NOTE: every always_comb output is assigned on all paths to avoid inferred latches.
   always_comb begin
      comb_in[0]  = dec_q;
      comb_in_tok = {comb_tok_q[NSTG-2:0], dec_tok_q};
      for (int k = 1; k < NSTG; k++) comb_in[k] = comb_q[k-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NSTG; k++) begin
            comb_q[k] <= '0;
            prev_q[k] <= '0;
         end
         comb_tok_q <= '0;
      end else if (clken) begin
         comb_tok_q <= comb_in_tok;
         for (int k = 0; k < NSTG; k++) begin
            if (comb_in_tok[k]) begin
               comb_q[k] <= comb_in[k] - prev_q[k];
               prev_q[k] <= comb_in[k];
            end
         end
      end
   end

   assign y_d = OW'(sat_trunc(longint'(signed'(comb_q[NSTG-1])), ACC_W, OW));

   always_ff @(posedge clk) begin
      if (reset) begin
         y_q   <= '0;
         tok_q <= 1'b0;
      end else if (clken) begin
         tok_q <= comb_tok_q[NSTG-1];
         if (comb_tok_q[NSTG-1]) y_q <= y_d;
      end
   end

   assign tok_o = tok_q;
   assign y_o   = y_q;

endmodule

// File: rtl/ddc_mix_cic.sv
// DDC stage: mixes ADC samples with NCO cos/-sin and decimates I/Q by 2^LOG2R
// through two CIC channels sharing one decimation counter.
module ddc_mix_cic
   import ddc_pkg::*;
#(
   parameter int DW    = DDC_DW,
   parameter int MPR   = DDC_MPR,
   parameter int NSTG  = DDC_NSTG,
   parameter int LOG2R = DDC_LOG2R,
   parameter int OW    = DDC_OW
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clken,
   input  logic signed [DW-1:0]  din,
   input  logic                 din_valid,
   input  logic signed [MPR-1:0] nco_sin,
   input  logic signed [MPR-1:0] nco_cos,
   input  logic                 nco_valid,
   output logic signed [OW-1:0]  i_out,
   output logic signed [OW-1:0]  q_out,
   output logic                 out_valid
);

   localparam int ACC_W = acc_width(DW, MPR, NSTG, LOG2R);
   localparam int PW    = DW + MPR;
   localparam int R     = 1 << LOG2R;

   logic                 accept;
   logic signed [PW-1:0] prod_i, prod_q;
   logic [ACC_W-1:0]     mix_i_q, mix_q_q;
   logic                 mix_tok_q;
   logic [LOG2R-1:0]     cnt_q, cnt_d;
   logic                 dec_take;
   logic                 i_int_tok, q_int_tok, int_tok;
   logic                 i_tok, q_tok, out_tok;
   logic [OW-1:0]        i_y, q_y;
   logic [OW-1:0]        i_out_q, q_out_q;
   logic                 out_valid_q;

   assign accept = din_valid & nco_valid;
   assign prod_i = PW'(din) * PW'(nco_cos);
   assign prod_q = -(PW'(din) * PW'(nco_sin));

   always_ff @(posedge clk) begin
      if (reset) begin
         mix_i_q   <= '0;
         mix_q_q   <= '0;
         mix_tok_q <= 1'b0;
      end else if (clken) begin
         mix_tok_q <= accept;
         if (accept) begin
            mix_i_q <= ACC_W'(prod_i);
            mix_q_q <= ACC_W'(prod_q);
         end
      end
   end

   assign int_tok  = i_int_tok & q_int_tok;
   assign dec_take = (cnt_q == LOG2R'(R - 1));
   assign cnt_d    = dec_take ? '0 : cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (reset)                  cnt_q <= '0;
      else if (clken && int_tok)  cnt_q <= cnt_d;
   end

   cic_dec_chan #(.ACC_W(ACC_W), .NSTG(NSTG), .OW(OW)) u_chan_i (
      .clk        (clk),
      .reset      (reset),
      .clken      (clken),
      .tok_i      (mix_tok_q),
      .x_i        (mix_i_q),
      .dec_take_i (dec_take),
      .int_tok_o  (i_int_tok),
      .tok_o      (i_tok),
      .y_o        (i_y)
   );

   cic_dec_chan #(.ACC_W(ACC_W), .NSTG(NSTG), .OW(OW)) u_chan_q (
      .clk        (clk),
      .reset      (reset),
      .clken      (clken),
      .tok_i      (mix_tok_q),
      .x_i        (mix_q_q),
      .dec_take_i (dec_take),
      .int_tok_o  (q_int_tok),
      .tok_o      (q_tok),
      .y_o        (q_y)
   );

   assign out_tok = i_tok & q_tok;

   // The valid pulse is cleared on any clk edge, not only enabled ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         i_out_q     <= '0;
         q_out_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= clken & out_tok;
         if (clken && out_tok) begin
            i_out_q <= i_y;
            q_out_q <= q_y;
         end
      end
   end

   assign i_out     = i_out_q;
   assign q_out     = q_out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ddc_mix_cic.sv
// Self-checking bench for ddc_mix_cic: directed and randomized stimulus against
// a model built from the CIC impulse response (boxcar of length 8, cubed).
module tb_ddc_mix_cic;

   logic               clk = 1'b0;
   logic               reset, clken, din_valid, nco_valid;
   logic signed [11:0] din, nco_sin, nco_cos;
   logic signed [15:0] i_out, q_out;
   logic               out_valid;

   always #5 clk = ~clk;

   ddc_mix_cic dut (
      .clk       (clk),
      .reset     (reset),
      .clken     (clken),
      .din       (din),
      .din_valid (din_valid),
      .nco_sin   (nco_sin),
      .nco_cos   (nco_cos),
      .nco_valid (nco_valid),
      .i_out     (i_out),
      .q_out     (q_out),
      .out_valid (out_valid)
   );

   typedef struct {
      longint      due;
      logic [15:0] i;
      logic [15:0] q;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   longint      h [22];
   longint      hist_i [$];
   longint      hist_q [$];
   exp_t        pend [$];
   longint      ce_cnt = 0;
   int          n_acc = 0;
   int          out_idx = 0;
   logic        exp_v;
   logic [15:0] last_i = '0;
   logic [15:0] last_q = '0;
   logic        settle_on = 1'b0;
   logic [15:0] settle_i, settle_q;

   function automatic logic [15:0] cic_out(input longint x[$]);
      longint y;
      longint r;
      int     idx;
      y = 0;
      for (int k = 0; k < 22; k++) begin
         idx = x.size() - 1 - k;
         if (idx >= 0) y += h[k] * x[idx];
      end
      r = (y + 65536) >>> 17;
      if (r > 32767) r = 32767;
      return r[15:0];
   endfunction

   task automatic step(input logic rst, input logic ce, input logic dv, input logic nv,
                       input logic [11:0] d, input logic [11:0] c, input logic [11:0] s);
      exp_t e;
      @(negedge clk);
      reset = rst; clken = ce; din_valid = dv; nco_valid = nv;
      din = d; nco_cos = c; nco_sin = s;
      @(posedge clk);
      #1;
      exp_v = 1'b0;
      if (rst) begin
         hist_i.delete(); hist_q.delete(); pend.delete();
         n_acc = 0; out_idx = 0; last_i = '0; last_q = '0;
      end else if (ce) begin
         ce_cnt++;
         if (dv && nv) begin
            hist_i.push_back(longint'(signed'(d)) * longint'(signed'(c)));
            hist_q.push_back(-(longint'(signed'(d)) * longint'(signed'(s))));
            if (hist_i.size() > 24) begin
               void'(hist_i.pop_front());
               void'(hist_q.pop_front());
            end
            n_acc++;
            if (n_acc % 8 == 0) begin
               e.due = ce_cnt + 9;
               e.i   = cic_out(hist_i);
               e.q   = cic_out(hist_q);
               pend.push_back(e);
            end
         end
         if (pend.size() > 0 && pend[0].due == ce_cnt) begin
            exp_v  = 1'b1;
            last_i = pend[0].i;
            last_q = pend[0].q;
            void'(pend.pop_front());
            out_idx++;
         end
      end
      checks++;
      assert (out_valid === exp_v) else begin
         errors++; $error("FAIL out_valid obs=%0b exp=%0b t=%0t", out_valid, exp_v, $time);
      end
      checks++;
      assert (i_out === last_i) else begin
         errors++; $error("FAIL i_out obs=%0d exp=%0d t=%0t", i_out, signed'(last_i), $time);
      end
      checks++;
      assert (q_out === last_q) else begin
         errors++; $error("FAIL q_out obs=%0d exp=%0d t=%0t", q_out, signed'(last_q), $time);
      end
      if (exp_v && settle_on && out_idx >= 4) begin
         checks++;
         assert (i_out === settle_i && q_out === settle_q) else begin
            errors++;
            $error("FAIL settled obs=%0d/%0d exp=%0d/%0d", i_out, q_out,
                   signed'(settle_i), signed'(settle_q));
         end
      end
   endtask

   task automatic run_const(input int n, input logic gated,
                            input logic [11:0] d, input logic [11:0] c, input logic [11:0] s);
      int acc;
      logic ce, dv;
      acc = 0;
      while (acc < n) begin
         ce = gated ? 1'($urandom_range(1, 0)) : 1'b1;
         dv = gated ? 1'($urandom_range(1, 0)) : 1'b1;
         step(1'b0, ce, dv, 1'b1, d, c, s);
         if (ce && dv) acc++;
      end
      for (int k = 0; k < 14; k++) step(1'b0, 1'b1, 1'b0, 1'b0, d, c, s);
   endtask

   initial begin
      for (int k = 0; k < 22; k++) h[k] = 0;
      for (int a = 0; a < 8; a++)
         for (int b = 0; b < 8; b++)
            for (int c = 0; c < 8; c++) h[a+b+c]++;

      // Reset held with live valid input, then exactly one group of 8 samples.
      for (int k = 0; k < 3; k++)
         step(1'b1, 1'b1, 1'b1, 1'b1, 12'(1000), 12'(2047), 12'(0));
      run_const(8, 1'b0, 12'(1000), 12'(2047), 12'(0));

      // DC on I only.
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      settle_on = 1'b1; settle_i = 16'(7996); settle_q = 16'(0);
      run_const(64, 1'b0, 12'(1000), 12'(2047), 12'(0));

      // Full-scale negative inputs.
      step(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0);
      settle_i = 16'(16384); settle_q = 16'(-16384);
      run_const(64, 1'b0, 12'(-2048), 12'(-2048), 12'(-2048));

      // DC with random clken / din_valid gaps.
      step(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0);
      settle_i = 16'(7996); settle_q = 16'(0);
      run_const(64, 1'b1, 12'(1000), 12'(2047), 12'(0));

      // Mid-group reset after sample 5; reset edge carries a valid sample to discard.
      step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
      settle_on = 1'b0;
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, 1'b1, 12'(1500), 12'(-900), 12'(700));
      step(1'b1, 1'b1, 1'b1, 1'b1, 12'(1500), 12'(-900), 12'(700));
      settle_on = 1'b1;
      run_const(64, 1'b0, 12'(1000), 12'(2047), 12'(0));

      // Fully random samples, NCO values and gating.
      step(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0);
      settle_on = 1'b0;
      for (int k = 0; k < 600; k++)
         step(1'b0, 1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0),
              1'($urandom_range(3, 0) != 0), 12'($urandom_range(4095, 0)),
              12'($urandom_range(4095, 0)), 12'($urandom_range(4095, 0)));
      for (int k = 0; k < 14; k++) step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);

      // Long DC run so every integrator wraps past 2^33.
      step(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0);
      settle_on = 1'b1; settle_i = 16'(7996); settle_q = 16'(0);
      run_const(6000, 1'b0, 12'(1000), 12'(2047), 12'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
